// File: rtl/mix_columns_iter.sv
// mix_columns_iter
// ----------------
// Iterative, handshaked AES MixColumns engine. One 128-bit state is accepted,
// COLS_PER_CYCLE columns are transformed in place per clock, and the result is
// held until the consumer takes it. INV=1 selects InvMixColumns (decrypt
// direction), INV=0 the forward matrix (used for loopback checking).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   in_data is valid
//   in_ready   engine is IDLE and can accept a state
//   in_data    [0:127] state; column c = in_data[c*32 +: 32], byte 0 leftmost
//   out_valid  out_data holds a completed result (state DONE)
//   out_ready  consumer accepts out_data
//   out_data   [0:127] transformed state, same packing as in_data
//   busy       high while columns are being transformed (state BUSY)

module mix_columns_iter #(
  parameter int INV            = 1,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  // Only 1, 2 and 4 columns per cycle tile the 4-column state evenly.
  if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  logic [0:127] data_r;
  logic [0:127] next_data_s;
  logic [1:0]   col_r;
  logic [1:0]   idx_s;
  logic         last_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the fixed matrix coefficients using an xtime chain.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] r;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (m)
      8'h01:   r = a;
      8'h02:   r = x2;
      8'h03:   r = x2 ^ a;
      8'h09:   r = x8 ^ a;
      8'h0b:   r = x8 ^ x2 ^ a;
      8'h0d:   r = x8 ^ x4 ^ a;
      8'h0e:   r = x8 ^ x4 ^ x2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // First-row coefficient d positions to the right; the matrix is circulant.
  function automatic logic [7:0] coef(input int d);
    logic [7:0] r;
    case (d)
      0:       r = (INV != 0) ? 8'h0e : 8'h02;
      1:       r = (INV != 0) ? 8'h0b : 8'h03;
      2:       r = (INV != 0) ? 8'h0d : 8'h01;
      3:       r = (INV != 0) ? 8'h09 : 8'h01;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // M * column; byte 0 of the column is its most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0]  b [4];
    logic [7:0]  acc;
    logic [31:0] res;
    res = 32'h0;
    for (int k = 0; k < 4; k++) begin
      b[k] = col[31-8*k -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) begin
        acc = acc ^ gf_mul_const(b[k], coef((k - r + 4) % 4));
      end
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  // Transform the column window starting at col_r; other columns pass through.
  always_comb begin
    next_data_s = data_r;
    idx_s       = col_r;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx_s = col_r + 2'(k);
      next_data_s[{idx_s, 5'b00000} +: 32] = mix_col(data_r[{idx_s, 5'b00000} +: 32]);
    end
  end

  // The window that ends on column 3 is the last one of the block.
  always_comb begin
    last_s = ((col_r + 2'(COLS_PER_CYCLE - 1)) == 2'd3);
  end

  // Control FSM with registered handshake/status outputs and the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= 128'h0;
      col_r       <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r     <= in_data;
            col_r      <= 2'd0;
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        BUSY: begin
          data_r <= next_data_s;
          col_r  <= col_r + 2'(COLS_PER_CYCLE);
          if (last_s) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          col_r       <= 2'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = data_r;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter. Four instances:
//   0: INV=1, COLS=1    1: INV=0, COLS=4    2: INV=1, COLS=2    3: INV=0, COLS=2
// Expected values come from known-answer vectors and a GF(2^8) reference model
// that uses polynomial multiplication followed by reduction modulo 0x11B.

module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid_a  [4];
  logic         in_ready_a  [4];
  logic [0:127] in_data_a   [4];
  logic         out_valid_a [4];
  logic         out_ready_a [4];
  logic [0:127] out_data_a  [4];
  logic         busy_a      [4];

  int errors = 0;
  int checks = 0;

  mix_columns_iter #(.INV(1), .COLS_PER_CYCLE(1)) u_inv_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_data(in_data_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .out_data(out_data_a[0]), .busy(busy_a[0]));

  mix_columns_iter #(.INV(0), .COLS_PER_CYCLE(4)) u_fwd_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_data(in_data_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .out_data(out_data_a[1]), .busy(busy_a[1]));

  mix_columns_iter #(.INV(1), .COLS_PER_CYCLE(2)) u_inv_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_data(in_data_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .out_data(out_data_a[2]), .busy(busy_a[2]));

  mix_columns_iter #(.INV(0), .COLS_PER_CYCLE(2)) u_fwd_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
    .in_data(in_data_a[3]), .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]),
    .out_data(out_data_a[3]), .busy(busy_a[3]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int j = 14; j >= 8; j--) if (p[j]) p = p ^ (15'h11b << (j - 8));
    return p[7:0];
  endfunction

  function automatic logic [0:127] ref_mix(input logic [0:127] s, input bit inv);
    logic [7:0]   m [16];
    logic [7:0]   acc;
    logic [0:127] o;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09,  8'h09, 8'h0e, 8'h0b, 8'h0d,
                   8'h0d, 8'h09, 8'h0e, 8'h0b,  8'h0b, 8'h0d, 8'h09, 8'h0e};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01,  8'h01, 8'h02, 8'h03, 8'h01,
                   8'h01, 8'h01, 8'h02, 8'h03,  8'h03, 8'h01, 8'h01, 8'h02};
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(m[r*4+k], s[c*32+k*8 +: 8]);
        o[c*32+r*8 +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept(input int i, input logic [0:127] d);
    in_valid_a[i] = 1'b1;
    in_data_a[i]  = d;
    chk("in_ready_before_accept", 128'(in_ready_a[i]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid_a[i] = 1'b0;
  endtask

  // Counts edges after the accept until out_valid, plus cycles seen busy.
  task automatic wait_out(input int i, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!out_valid_a[i] && lat < 20) begin
      if (busy_a[i]) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out(input int i);
    out_ready_a[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_a[i] = 1'b0;
    chk("in_ready_after_take", 128'(in_ready_a[i]), 128'd1);
    chk("out_valid_after_take", 128'(out_valid_a[i]), 128'd0);
  endtask

  task automatic run(input int i, input logic [0:127] d, input int exp_lat,
                     output logic [0:127] res);
    int lat;
    int bc;
    accept(i, d);
    wait_out(i, lat, bc);
    chk("latency", 128'(lat), 128'(exp_lat));
    chk("busy_cycles", 128'(bc), 128'(exp_lat));
    res = out_data_a[i];
    release_out(i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [0:127] r;
    logic [0:127] y;
    logic [0:127] x;
    logic [0:127] held;
    logic [0:127] exp_q [$];
    int lat, bc, results, cyc, last_acc, overlap;
    bit pending, rst_valid_seen;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid_a[i]  = 1'b0;
      in_data_a[i]   = 128'h0;
      out_ready_a[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_in_ready",  128'(in_ready_a[i]),  128'd1);
      chk("reset_out_valid", 128'(out_valid_a[i]), 128'd0);
      chk("reset_busy",      128'(busy_a[i]),      128'd0);
      chk("reset_out_data",  out_data_a[i],        128'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 1: InvMixColumns known answer, one column per cycle
    run(0, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 4, r);
    chk("t1_kat", r, 128'hdb135345_f20a225c_01010101_d4d4d4d5);

    // 2: forward known answer, four columns per cycle
    run(1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1, r);
    chk("t2_kat", r, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

    // 3: backpressure in DONE with in_valid asserted
    x = rnd128();
    accept(0, x);
    wait_out(0, lat, bc);
    chk("t3_latency", 128'(lat), 128'd4);
    held = out_data_a[0];
    chk("t3_result", held, ref_mix(x, 1'b1));
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = rnd128();
    for (int k = 0; k < 10; k++) begin
      chk("t3_out_valid_held", 128'(out_valid_a[0]), 128'd1);
      chk("t3_out_data_held",  out_data_a[0],        held);
      chk("t3_in_ready_low",   128'(in_ready_a[0]),  128'd0);
      @(negedge clk);
    end
    in_valid_a[0] = 1'b0;
    release_out(0);
    chk("t3_idle_holds_result", out_data_a[0], held);
    chk("t3_idle_not_busy", 128'(busy_a[0]), 128'd0);

    // 4: asynchronous reset two cycles into BUSY
    accept(0, rnd128());
    @(negedge clk);
    @(negedge clk);
    chk("t4_busy_before_reset", 128'(busy_a[0]), 128'd1);
    rst = 1'b1;
    #1;
    chk("t4_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("t4_busy",      128'(busy_a[0]),      128'd0);
    chk("t4_in_ready",  128'(in_ready_a[0]),  128'd1);
    chk("t4_out_data",  out_data_a[0],        128'h0);
    @(negedge clk);
    rst = 1'b0;
    rst_valid_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid_a[0]) rst_valid_seen = 1'b1;
    end
    chk("t4_no_result_after_abort", 128'(rst_valid_seen), 128'd0);
    x = rnd128();
    run(0, x, 4, r);
    chk("t4_after_reset", r, ref_mix(x, 1'b1));

    // 5: back-to-back random states, in_valid held high, two columns per cycle
    in_valid_a[2]  = 1'b1;
    out_ready_a[2] = 1'b1;
    in_data_a[2]   = rnd128();
    results = 0; cyc = 0; last_acc = -1; pending = 1'b0; overlap = 0;
    while (results < 100 && cyc < 2000) begin
      if (in_ready_a[2] && (busy_a[2] || out_valid_a[2])) overlap++;
      if (in_ready_a[2]) begin
        exp_q.push_back(ref_mix(in_data_a[2], 1'b1));
        if (last_acc >= 0) chk("t5_accept_gap", 128'(cyc - last_acc), 128'd4);
        last_acc = cyc;
        pending  = 1'b1;
      end
      if (out_valid_a[2]) begin
        if (exp_q.size() == 0) chk("t5_unexpected_result", 128'd1, 128'd0);
        else chk("t5_result", out_data_a[2], exp_q.pop_front());
        results++;
      end
      @(negedge clk);
      cyc++;
      if (pending) begin
        in_data_a[2] = rnd128();
        pending = 1'b0;
      end
    end
    in_valid_a[2] = 1'b0;
    chk("t5_result_count", 128'(results), 128'd100);
    chk("t5_no_accept_in_busy_done", 128'(overlap), 128'd0);
    for (int k = 0; k < 20 && !in_ready_a[2]; k++) @(negedge clk);
    out_ready_a[2] = 1'b0;
    chk("t5_drained", 128'(in_ready_a[2]), 128'd1);

    // 6: forward then inverse round trip
    for (int n = 0; n < 100; n++) begin
      x = rnd128();
      run(3, x, 2, y);
      chk("t6_forward", y, ref_mix(x, 1'b0));
      run(2, y, 2, r);
      chk("t6_roundtrip", r, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative, handshaked MixColumns engine for the AES datapath.
- Default mode is InvMixColumns (decrypt direction); forward mode is available for loopback checking.
- Accepts one 128-bit state and transforms COLS_PER_CYCLE columns per clock in place, then holds the result until the consumer takes it.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the sequential decrypt round, where area matters more than throughput.

Parameters:
- INV, 1: 1 = InvMixColumns matrix rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}; 0 = forward matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
- COLS_PER_CYCLE, 1: columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous reset, active-high.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a state.
- in_data, input, [0:127]: state. Column c is in_data[c*32 +: 32]; byte r of a column is bits [r*8 +: 8], so byte 0 is the leftmost.
- out_valid, output, 1: out_data holds a completed result.
- out_ready, input, 1: consumer accepts out_data.
- out_data, output, [0:127]: transformed state, same packing as in_data.
- busy, output, 1: high while in state BUSY.

Behaviour:
- States are IDLE, BUSY and DONE. Reset enters IDLE, clears the state register and column counter to 0, and deasserts out_valid and busy.
- Reset values: in_ready = 1, out_valid = 0, busy = 0, out_data = 128'h0.
- in_ready = (state == IDLE), out_valid = (state == DONE), busy = (state == BUSY). All three are pure state decodes.
- out_data is driven directly from the state register.
- IDLE: on in_valid && in_ready at a rising edge, capture in_data, set col = 0, go to BUSY. While in_valid is low, hold.
- BUSY: each cycle, replace columns col .. col+COLS_PER_CYCLE-1 with M·column over GF(2^8), reduction polynomial 0x11B.
  - Each byte product is built from xtime chains: xtime(a) = (a<<1) ^ (a[7] ? 8'h1b : 8'h00).
  - Increment col by COLS_PER_CYCLE. col is 2 bits wide and wraps to 0.
  - On the cycle that processes column 3, go to DONE.
  - in_valid is ignored while in BUSY.
- Latency: a state accepted at edge k has out_valid high after edge k + 4/COLS_PER_CYCLE, i.e. 4, 2 or 1 cycles.
- DONE: out_data is held stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle turnaround.
- Throughput is one block per 4/COLS_PER_CYCLE + 2 cycles.
- out_data outside DONE:
  - In BUSY it shows partially transformed data and is not meaningful.
  - In IDLE it holds the last completed result until the next accept overwrites it.
- Reset mid-operation: asserting rst in BUSY or DONE aborts immediately and asynchronously. No out_valid pulse is produced. The aborted block is lost.
- Unused multiplier values never occur, because the matrix is fixed by INV. No X propagation is allowed on out_data.
- Transform results must match the combinational MixColumns module of the same direction, bit for bit.

Test Plan:
1. INV=1, COLS_PER_CYCLE=1, out_ready=1: send in_data 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6.
   - Required: out_data = 128'hdb135345_f20a225c_01010101_d4d4d4d5.
   - out_valid rises exactly 4 cycles after accept; busy is high for those 4 cycles.
2. INV=0, COLS_PER_CYCLE=4: send in_data 128'hdb135345_f20a225c_01010101_c6c6c6c6.
   - Required: out_data = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, after 1-cycle latency.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE.
   - Required: out_valid stays 1, out_data is unchanged, and in_ready stays 0 even while in_valid is high.
   - Then pulse out_ready: IDLE follows, and in_ready = 1 on the next cycle.
4. Reset mid-op: assert rst 2 cycles into BUSY (COLS_PER_CYCLE=1).
   - Required: out_valid = 0, busy = 0, in_ready = 1, out_data = 0 immediately, with no result emitted.
   - A new block afterwards produces the correct result.
5. Back-to-back, INV=1, COLS_PER_CYCLE=2, with in_valid held high carrying 100 random states.
   - Required: each result equals the reference model, one accept per 4 cycles, no accept during BUSY or DONE.
6. Round-trip: 100 random states through the INV=0 instance and then the INV=1 instance, same COLS_PER_CYCLE.
   - Required: output equals the original input for every state.
